// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operands and opcode. Stage 2 computes and registers
// the result and flags. An internal carry flag (cf) feeds carry, borrow and
// rotate ops, so multi-word arithmetic can be streamed through the block.
// Optional build macro ALU_PIPE_OVF_EN adds a registered signed-overflow
// output (ovf).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctl,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             err
`ifdef ALU_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [3:0] OP_SEL   = 4'd0;
    localparam logic [3:0] OP_INC   = 4'd1;
    localparam logic [3:0] OP_DEC   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_ADD_C = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SUB_B = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_ROL   = 4'd12;
    localparam logic [3:0] OP_ROR   = 4'd13;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_ctl_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             err_q;
    logic             cf_q;

    logic             s2_adv;
    logic             cf_in;
    logic [WIDTH:0]   a_x;
    logic [WIDTH:0]   b_x;
    logic [WIDTH:0]   cin_x;
    logic [WIDTH:0]   one_x;
    logic [WIDTH:0]   wide;
    logic             op_err;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;
    logic             neg_d;

    assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;

    // A flag_clr on the same edge as an S2 entry must already be seen by that op.
    assign cf_in = cf_q & ~flag_clr;

    // Stage 1: accept a new op whenever the slot is free or draining this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ctl_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q   <= a;
                s1_b_q   <= b;
                s1_ctl_q <= ctl;
            end
        end
    end

    // Stage 2 datapath: everything is computed one bit wider so bit WIDTH is the carry/borrow.
    always_comb begin
        a_x    = {1'b0, s1_a_q};
        b_x    = {1'b0, s1_b_q};
        cin_x  = {{WIDTH{1'b0}}, cf_in};
        one_x  = {{WIDTH{1'b0}}, 1'b1};
        wide   = '0;
        op_err = 1'b0;
        case (s1_ctl_q)
            OP_SEL:   wide = b_x;
            OP_INC:   wide = b_x + one_x;
            OP_DEC:   wide = b_x - one_x;
            OP_ADD:   wide = a_x + b_x;
            OP_ADD_C: wide = a_x + b_x + cin_x;
            OP_SUB:   wide = a_x - b_x;
            OP_SUB_B: wide = a_x - b_x - cin_x;
            OP_AND:   wide = {1'b0, s1_a_q & s1_b_q};
            OP_OR:    wide = {1'b0, s1_a_q | s1_b_q};
            OP_XOR:   wide = {1'b0, s1_a_q ^ s1_b_q};
            OP_SHL:   wide = {s1_a_q, 1'b0};
            OP_SHR:   wide = {s1_a_q[0], 1'b0, s1_a_q[WIDTH-1:1]};
            OP_ROL:   wide = {s1_a_q, cf_in};
            OP_ROR:   wide = {s1_a_q[0], cf_in, s1_a_q[WIDTH-1:1]};
            default:  op_err = 1'b1;
        endcase
        result_d = wide[WIDTH-1:0];
        carry_d  = op_err ? cf_in : wide[WIDTH];
        zero_d   = ~op_err & (result_d == '0);
        neg_d    = result_d[WIDTH-1];
    end

    // Stage 2 registers: load on advance, otherwise hold until the consumer takes the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            err_q       <= op_err;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Carry flag: takes the carry of each valid op entering S2; invalid ops leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cf_q <= 1'b0;
        end else if (s2_adv && !op_err) begin
            cf_q <= carry_d;
        end else if (flag_clr) begin
            cf_q <= 1'b0;
        end
    end

`ifdef ALU_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: operands of matching sign (add) or differing sign (sub) yielding a flipped sign.
    always_comb begin
        ovf_d = 1'b0;
        case (s1_ctl_q)
            OP_INC:             ovf_d = ~s1_b_q[WIDTH-1] & result_d[WIDTH-1];
            OP_DEC:             ovf_d = s1_b_q[WIDTH-1] & ~result_d[WIDTH-1];
            OP_ADD, OP_ADD_C:   ovf_d = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &
                                        (result_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            OP_SUB, OP_SUB_B:   ovf_d = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &
                                        (result_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            default:            ovf_d = 1'b0;
        endcase
    end

    // Overflow register shares the stage-2 load/hold timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (s2_adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign err       = err_q;

endmodule
